// File: rtl/sdram_test_sequencer_if.sv
// Controller-side request/ack bus between sdram_test_sequencer and sdram_controller.
// The sequencer uses the master modport; the controller (or a model of it) uses slave.
interface sdram_test_sequencer_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 128
);
  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data;
  logic              iread_ack;

  modport master (
    output owrite_req, owrite_address, owrite_data,
    input  iwrite_ack,
    output oread_req, oread_address,
    input  iread_data, iread_ack
  );

  modport slave (
    input  owrite_req, owrite_address, owrite_data,
    output iwrite_ack,
    input  oread_req, oread_address,
    output iread_data, iread_ack
  );
endinterface

// File: rtl/sdram_test_sequencer.sv
// SDRAM exerciser: manual single writes/reads and an automatic write/readback sweep
// over DEPTH consecutive addresses, reporting pass/fail, error count and first bad address.
// Optional feature macro: SDRAM_SEQ_TIMEOUT_EN enables the ack watchdog and the TOUT state.
module sdram_test_sequencer #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 22,
  parameter int DEPTH   = 4,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    iclk,
  input  logic                    ireset,
  input  logic                    icmd_write,
  input  logic                    icmd_read,
  input  logic                    icmd_sweep,
  input  logic [ADDR_W-1:0]       iaddress,
  input  logic [DATA_W-1:0]       idata,
  sdram_test_sequencer_if.master  mem,
  output logic [DATA_W-1:0]       odata,
  output logic                    obusy,
  output logic                    odone,
  output logic                    opass,
  output logic [ERR_W-1:0]        oerr_count,
  output logic [ADDR_W-1:0]       oerr_addr,
  output logic                    otimeout,
  output logic [2:0]              ostate
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    SW_WR = 3'd3,
    SW_RD = 3'd4,
    DONE  = 3'd5,
    TOUT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cmd_prev_q, cmd_prev_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              timeout_q, timeout_d;

  logic              wr_edge, rd_edge, sw_edge;
  logic              idx_last;
  logic [IDX_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] expected;

`ifdef SDRAM_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state, handshake and result logic; every register defaults to holding its value.
  always_comb begin
    state_d     = state_q;
    cmd_prev_d  = {icmd_sweep, icmd_read, icmd_write};
    idx_d       = idx_q;
    base_d      = base_q;
    seed_d      = seed_q;
    wr_req_d    = wr_req_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    timeout_d   = timeout_q;

    wr_edge   = icmd_write & ~cmd_prev_q[0];
    rd_edge   = icmd_read  & ~cmd_prev_q[1];
    sw_edge   = icmd_sweep & ~cmd_prev_q[2];
    idx_last  = (idx_q == IDX_W'(DEPTH - 1));
    idx_inc   = idx_q + IDX_W'(1);
    next_addr = base_q + ADDR_W'(idx_inc);
    expected  = seed_q + DATA_W'(idx_q);

    case (state_q)
      IDLE: begin
        if (wr_edge) begin
          state_d   = WR;
          wr_req_d  = 1'b1;
          wr_addr_d = iaddress;
          wr_data_d = idata;
          timeout_d = 1'b0;
        end else if (rd_edge) begin
          state_d   = RD;
          rd_req_d  = 1'b1;
          rd_addr_d = iaddress;
          timeout_d = 1'b0;
        end else if (sw_edge) begin
          state_d     = SW_WR;
          base_d      = iaddress;
          seed_d      = idata;
          idx_d       = '0;
          wr_req_d    = 1'b1;
          wr_addr_d   = iaddress;
          wr_data_d   = idata;
          err_count_d = '0;
          err_addr_d  = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      WR: begin
        if (mem.iwrite_ack) begin
          state_d  = IDLE;
          wr_req_d = 1'b0;
        end
      end
      RD: begin
        if (mem.iread_ack) begin
          state_d  = IDLE;
          rd_req_d = 1'b0;
          data_d   = mem.iread_data;
        end
      end
      SW_WR: begin
        if (mem.iwrite_ack) begin
          if (idx_last) begin
            state_d   = SW_RD;
            idx_d     = '0;
            wr_req_d  = 1'b0;
            rd_req_d  = 1'b1;
            rd_addr_d = base_q;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = next_addr;
            wr_data_d = seed_q + DATA_W'(idx_inc);
          end
        end
      end
      SW_RD: begin
        if (mem.iread_ack) begin
          data_d = mem.iread_data;
          if (mem.iread_data != expected) begin
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (err_count_q == '0) begin
              err_addr_d = rd_addr_q;
            end
          end
          if (idx_last) begin
            state_d  = DONE;
            idx_d    = '0;
            rd_req_d = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_count_d == '0);
          end else begin
            idx_d     = idx_inc;
            rd_addr_d = next_addr;
          end
        end
      end
      DONE:    state_d = IDLE;
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SDRAM_SEQ_TIMEOUT_EN
    tmo_cnt_d = '0;
    if (wr_req_q | rd_req_q) begin
      if ((wr_req_q & mem.iwrite_ack) | (rd_req_q & mem.iread_ack)) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_cnt_d = '0;
        state_d   = TOUT;
        idx_d     = '0;
        wr_req_d  = 1'b0;
        rd_req_d  = 1'b0;
        timeout_d = 1'b1;
        pass_d    = 1'b0;
        done_d    = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-high reset to all zeros / IDLE.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q     <= IDLE;
      cmd_prev_q  <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      timeout_q   <= 1'b0;
`ifdef SDRAM_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_prev_q  <= cmd_prev_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      timeout_q   <= timeout_d;
`ifdef SDRAM_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign mem.owrite_req     = wr_req_q;
  assign mem.owrite_address = wr_addr_q;
  assign mem.owrite_data    = wr_data_q;
  assign mem.oread_req      = rd_req_q;
  assign mem.oread_address  = rd_addr_q;
  assign odata              = data_q;
  assign obusy              = busy_q;
  assign odone              = done_q;
  assign opass              = pass_q;
  assign oerr_count         = err_count_q;
  assign oerr_addr          = err_addr_q;
  assign otimeout           = timeout_q;
  assign ostate             = state_q;

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Directed self-checking bench for sdram_test_sequencer: manual write/read, clean and
// faulty wrapping sweeps, command priority/ignoring, reset mid-sweep, and (with
// SDRAM_SEQ_TIMEOUT_EN) the ack watchdog.
module tb_sdram_test_sequencer;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 22;
  localparam int DEPTH   = 4;
  localparam int ERR_W   = 16;
  localparam int TIMEOUT = 16;

  logic              iclk = 1'b0;
  logic              ireset;
  logic              icmd_write, icmd_read, icmd_sweep;
  logic [ADDR_W-1:0] iaddress;
  logic [DATA_W-1:0] idata;
  logic [DATA_W-1:0] odata;
  logic              obusy, odone, opass, otimeout;
  logic [ERR_W-1:0]  oerr_count;
  logic [ADDR_W-1:0] oerr_addr;
  logic [2:0]        ostate;

  int total = 0;
  int bad   = 0;

  sdram_test_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_test_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(ERR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .iclk(iclk), .ireset(ireset),
    .icmd_write(icmd_write), .icmd_read(icmd_read), .icmd_sweep(icmd_sweep),
    .iaddress(iaddress), .idata(idata),
    .mem(bus),
    .odata(odata), .obusy(obusy), .odone(odone), .opass(opass),
    .oerr_count(oerr_count), .oerr_addr(oerr_addr), .otimeout(otimeout), .ostate(ostate)
  );

  // 100 MHz-style free-running clock
  always #5 iclk = ~iclk;

  // Hard stop in case something stalls beyond every bounded wait
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=stall expected=finish");
    $fatal(1, "[TB] simulation stalled");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic rd, input logic sw,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    icmd_write = wr;
    icmd_read  = rd;
    icmd_sweep = sw;
    iaddress   = addr;
    idata      = data;
  endtask

  // Bounded wait for a write request, check its payload, then ack it for one edge
  task automatic write_handshake(input string tag, input logic [ADDR_W-1:0] exp_addr,
                                 input logic [DATA_W-1:0] exp_data);
    int waited = 0;
    while (bus.owrite_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check_output({tag, "_req"}, DATA_W'(bus.owrite_req), DATA_W'(1));
    check_output({tag, "_addr"}, DATA_W'(bus.owrite_address), DATA_W'(exp_addr));
    check_output({tag, "_data"}, bus.owrite_data, exp_data);
    bus.iwrite_ack = 1'b1;
    tick();
    bus.iwrite_ack = 1'b0;
  endtask

  // Bounded wait for a read request, check its address, then return rdata with ack
  task automatic read_handshake(input string tag, input logic [ADDR_W-1:0] exp_addr,
                                input logic [DATA_W-1:0] rdata);
    int waited = 0;
    while (bus.oread_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check_output({tag, "_req"}, DATA_W'(bus.oread_req), DATA_W'(1));
    check_output({tag, "_addr"}, DATA_W'(bus.oread_address), DATA_W'(exp_addr));
    bus.iread_data = rdata;
    bus.iread_ack  = 1'b1;
    tick();
    bus.iread_ack  = 1'b0;
    bus.iread_data = '0;
  endtask

  initial begin
    logic [ADDR_W-1:0] sweep_addr [DEPTH];
    int hi_cycles;
    sweep_addr[0] = 22'h3FFFFE;
    sweep_addr[1] = 22'h3FFFFF;
    sweep_addr[2] = 22'h000000;
    sweep_addr[3] = 22'h000001;

    ireset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
    bus.iwrite_ack = 1'b0;
    bus.iread_ack  = 1'b0;
    bus.iread_data = '0;
    tick();
    tick();
    ireset = 1'b0;

    // Reset state
    check_output("rst_state", DATA_W'(ostate), DATA_W'(0));
    check_output("rst_flags", DATA_W'({obusy, odone, opass, otimeout, bus.owrite_req, bus.oread_req}),
                 DATA_W'(0));
    check_output("rst_odata", odata, DATA_W'(0));
    check_output("rst_errcnt", DATA_W'(oerr_count), DATA_W'(0));
    tick();

    // Manual write: ack on the 4th request cycle -> request high exactly 4 cycles
    apply_stimulus(1'b1, 1'b0, 1'b0, 22'd2, 128'hA5);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'd2, 128'hA5);
    check_output("mw_state", DATA_W'(ostate), DATA_W'(1));
    check_output("mw_addr", DATA_W'(bus.owrite_address), DATA_W'(2));
    check_output("mw_data", bus.owrite_data, DATA_W'(128'hA5));
    hi_cycles = (bus.owrite_req === 1'b1) ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) bus.iwrite_ack = 1'b1;
      tick();
      bus.iwrite_ack = 1'b0;
      if (bus.owrite_req === 1'b1) hi_cycles++;
    end
    check_output("mw_req_cycles", DATA_W'(hi_cycles), DATA_W'(4));
    check_output("mw_busy_end", DATA_W'({obusy, ostate}), DATA_W'(0));

    // Manual read returning 0xA5
    apply_stimulus(1'b0, 1'b1, 1'b0, 22'd2, '0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'd2, '0);
    check_output("mr_state", DATA_W'(ostate), DATA_W'(2));
    read_handshake("mr", 22'd2, 128'hA5);
    check_output("mr_odata", odata, DATA_W'(128'hA5));
    check_output("mr_req_low", DATA_W'(bus.oread_req), DATA_W'(0));
    check_output("mr_busy_end", DATA_W'(obusy), DATA_W'(0));
    tick();

    // Clean sweep wrapping past all-ones
    apply_stimulus(1'b0, 1'b0, 1'b1, 22'h3FFFFE, 128'h10);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'h3FFFFE, 128'h10);
    check_output("cs_state_wr", DATA_W'(ostate), DATA_W'(3));
    for (int i = 0; i < DEPTH; i++)
      write_handshake($sformatf("cs_w%0d", i), sweep_addr[i], DATA_W'(128'h10 + i));
    check_output("cs_state_rd", DATA_W'(ostate), DATA_W'(4));
    check_output("cs_wreq_low", DATA_W'(bus.owrite_req), DATA_W'(0));
    for (int i = 0; i < DEPTH; i++)
      read_handshake($sformatf("cs_r%0d", i), sweep_addr[i], DATA_W'(128'h10 + i));
    check_output("cs_done_cycle", DATA_W'({odone, ostate}), DATA_W'({1'b1, 3'd5}));
    check_output("cs_pass_at_done", DATA_W'(opass), DATA_W'(1));
    tick();
    check_output("cs_done_pulse", DATA_W'({odone, ostate}), DATA_W'(0));
    check_output("cs_pass", DATA_W'(opass), DATA_W'(1));
    check_output("cs_errcnt", DATA_W'(oerr_count), DATA_W'(0));
    check_output("cs_odata", odata, DATA_W'(128'h13));

    // Faulty sweep: reads 1 and 3 come back with bit 0 flipped
    apply_stimulus(1'b0, 1'b0, 1'b1, 22'h3FFFFE, 128'h10);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'h3FFFFE, 128'h10);
    check_output("fs_pass_cleared", DATA_W'(opass), DATA_W'(0));
    for (int i = 0; i < DEPTH; i++)
      write_handshake($sformatf("fs_w%0d", i), sweep_addr[i], DATA_W'(128'h10 + i));
    for (int i = 0; i < DEPTH; i++)
      read_handshake($sformatf("fs_r%0d", i), sweep_addr[i],
                     DATA_W'(128'h10 + i) ^ ((i % 2 == 1) ? DATA_W'(1) : DATA_W'(0)));
    check_output("fs_done", DATA_W'(odone), DATA_W'(1));
    tick();
    check_output("fs_errcnt", DATA_W'(oerr_count), DATA_W'(2));
    check_output("fs_erraddr", DATA_W'(oerr_addr), DATA_W'(22'h3FFFFF));
    check_output("fs_pass", DATA_W'(opass), DATA_W'(0));

    // Simultaneous write+sweep edges: write wins, sweep dropped
    apply_stimulus(1'b1, 1'b0, 1'b1, 22'd5, 128'h77);
    tick();
    check_output("sim_state", DATA_W'(ostate), DATA_W'(1));
    check_output("sim_waddr", DATA_W'(bus.owrite_address), DATA_W'(5));
    check_output("sim_errcnt_kept", DATA_W'(oerr_count), DATA_W'(2));
    // Read edge while in WR is dropped
    apply_stimulus(1'b1, 1'b1, 1'b1, 22'd6, 128'h77);
    tick();
    check_output("ign_rd_state", DATA_W'(ostate), DATA_W'(1));
    check_output("ign_rd_req", DATA_W'(bus.oread_req), DATA_W'(0));
    write_handshake("sim_w", 22'd5, 128'h77);
    check_output("sim_idle", DATA_W'(ostate), DATA_W'(0));
    tick();
    check_output("ign_held_cmds", DATA_W'({obusy, ostate}), DATA_W'(0));
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'd6, '0);
    tick();
    // Stray read ack in IDLE
    bus.iread_data = 128'hDEAD;
    bus.iread_ack  = 1'b1;
    tick();
    bus.iread_ack  = 1'b0;
    bus.iread_data = '0;
    check_output("stray_ack_odata", odata, DATA_W'(128'h12));
    check_output("stray_ack_state", DATA_W'(ostate), DATA_W'(0));
    tick();

    // Reset while a sweep read request is pending
    apply_stimulus(1'b0, 1'b0, 1'b1, 22'h100, 128'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 22'h100, 128'h0);
    for (int i = 0; i < DEPTH; i++)
      write_handshake($sformatf("rs_w%0d", i), ADDR_W'(22'h100 + i), DATA_W'(i));
    check_output("rs_in_swrd", DATA_W'({bus.oread_req, ostate}), DATA_W'({1'b1, 3'd4}));
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    check_output("rs_req_low", DATA_W'({bus.oread_req, bus.owrite_req}), DATA_W'(0));
    check_output("rs_flags", DATA_W'({obusy, odone, opass, otimeout, ostate}), DATA_W'(0));
    check_output("rs_counts", DATA_W'({oerr_count, oerr_addr}), DATA_W'(0));
    check_output("rs_odata", odata, DATA_W'(0));
    bus.iread_data = 128'h55;
    bus.iread_ack  = 1'b1;
    tick();
    bus.iread_ack  = 1'b0;
    bus.iread_data = '0;
    check_output("rs_late_ack", DATA_W'({odata[7:0], obusy, ostate}), DATA_W'(0));
    tick();

`ifdef SDRAM_SEQ_TIMEOUT_EN
    // Watchdog: controller never acks
    begin
      logic saw_tout;
      saw_tout = 1'b0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 22'd9, 128'h9);
      tick();
      apply_stimulus(1'b0, 1'b0, 1'b0, 22'd9, 128'h9);
      hi_cycles = (bus.owrite_req === 1'b1) ? 1 : 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (bus.owrite_req === 1'b1) hi_cycles++;
        if (ostate === 3'd6 && odone === 1'b1) saw_tout = 1'b1;
      end
      check_output("to_req_cycles", DATA_W'(hi_cycles), DATA_W'(TIMEOUT));
      check_output("to_tout_done", DATA_W'(saw_tout), DATA_W'(1));
      check_output("to_flag", DATA_W'(otimeout), DATA_W'(1));
      check_output("to_idle", DATA_W'(ostate), DATA_W'(0));
    end
`else
    check_output("to_tied_low", DATA_W'(otimeout), DATA_W'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
